keeper_round_ctrl: RTL and testbench
====================================

// Module: keeper_round_ctrl
// PURPOSE
//  Parametrised goalkeeper-round controller: sequences one keeper round (engage, react window,
//  judge, show result), overlays the shot target on the VGA stream, and keeps a per-match
//  round/goal tally with a match-over flag. Sits in the control chain between the mouse/UART
//  front end and the screen-text/score logic; replaces the fixed-timing keeper controller.
// PARAMETERS
//  CLK_HZ      65_000_000  clock frequency, used to derive the 1 ms tick
//  ENGAGE_MS   1000        SOLO delay from entering KEEPER to react window
//  REACT_MS    1000        react window length (both modes)
//  SHOW_MS     200         GOAL/MISS display length
//  WAIT_MS     5000        MULTI: max wait for enemy_input before auto-forfeit (counted as MISS)
//  TARGET_W    100         target box width, pixels
//  TARGET_H    100         target box height, pixels
//  SAVE_MARGIN 0           extra pixels added on every side of the box when judging a save
//  MAX_ROUNDS  5           rounds per match; 1..15
// PORTS
//  clk          in   1     system clock
//  rst          in   1     synchronous active-high reset
//  xpos         in   12    mouse (glove) x
//  ypos         in   12    mouse (glove) y
//  game_state   in   g_state  round active only while == KEEPER
//  game_mode    in   g_mode   SOLO / MULTI
//  shot_xpos    in   10    target top-left x, sampled at window start
//  shot_ypos    in   10    target top-left y, sampled at window start
//  enemy_input  in   1     MULTI: shooter finished (level, sampled each cycle)
//  is_scored    out  1     1 while in GOAL
//  round_done   out  1     single-cycle pulse at end of SHOW
//  end_gk       out  1     single-cycle pulse when returning to IDLE after a completed round
//  goals_cnt    out  4     goals conceded this match
//  round_cnt    out  4     completed rounds this match
//  match_over   out  1     level, set when round_cnt reaches MAX_ROUNDS
//  in           vga_if.in  video in;  out  vga_if.out  video out
// BEHAVIOUR
//  Reset: all outputs 0, out.* 0, state IDLE, counters 0. Reset is synchronous active-high and
//  aborts any round with no pulses.
//  Timing: ms_tick every CLK_HZ/1000 cycles; phase timers count ticks, cleared on every state change.
//  Video: every out.* field is registered 1 cycle after in.*; rgb overlay uses in.hcount/vcount.
//  Inside box: h in [sx, sx+TARGET_W-1], v in [sy, sy+TARGET_H-1]; compute in 13 bits, no wrap.
//  FSM:
//   IDLE      -> ENGAGE when game_state==KEEPER && !match_over.
//   ENGAGE    SOLO: after ENGAGE_MS -> REACT. MULTI: enemy_input==1 -> REACT;
//             WAIT_MS elapsed -> MISS (forfeit). Latch shot_xpos/ypos on exit to REACT.
//   REACT     box drawn 12'h00F (see CONFIG); after REACT_MS -> JUDGE.
//   JUDGE     1 cycle; save if xpos in [sx-M, sx+TARGET_W-1+M] and same for y, M=SAVE_MARGIN,
//             lower bound clamped at 0 -> MISS; else -> GOAL.
//   GOAL/MISS box 12'hF00 / 12'h0F0 for SHOW_MS; round_done pulses on the last cycle;
//             round_cnt+1, goals_cnt+1 if GOAL, in that same cycle -> TERM.
//   TERM      1 cycle, end_gk=1 -> IDLE.
//  game_state != KEEPER in ENGAGE/REACT: -> IDLE, no pulses, tally unchanged. From JUDGE on,
//  the round completes regardless.
//  game_mode is sampled at IDLE->ENGAGE and held for the round.
//  Tally saturates at MAX_ROUNDS. match_over stays until rst or game_state==START is seen in IDLE,
//  which clears goals_cnt, round_cnt and match_over.
//  Illegal state: rgb 12'h00F, -> IDLE.
// CONFIGURATION
//  KEEPER_TARGET_HINT_EN defined: target box drawn during REACT (training aid).
//  Not defined: REACT draws nothing (out.rgb = in.rgb); GOAL/MISS still show the box.
// STRUCTURE
//  game_pkg: g_state, g_mode, keeper FSM enum, colour constants (C_HINT, C_GOAL, C_SAVE).
//  Sub-module: ms_tick_gen #(CLK_HZ) -> 1-cycle ms_tick. Reuse delay for the video sync pipe.
// TESTING (CLK_HZ=1000 so 1 tick per cycle, ENGAGE/REACT=10, SHOW=4, WAIT=20, MAX_ROUNDS=2)
//  SOLO, KEEPER, glove (150,150), shot (100,100) -> MISS at cycle ~21, round_done 1 pulse,
//   is_scored=0, round_cnt=1, goals_cnt=0.
//  SOLO, glove (400,400), same shot -> GOAL, is_scored high for 4 cycles, goals_cnt=1.
//  MULTI, enemy_input never -> forfeit MISS after 20 ticks; enemy_input at tick 3 -> REACT at 4.
//  SAVE_MARGIN=5, glove (95,95) vs shot (100,100) -> MISS (save); glove (94,100) -> GOAL.
//  game_state leaves KEEPER mid-REACT -> IDLE, no round_done/end_gk, tally unchanged.
//  Two rounds -> match_over=1, IDLE stays IDLE in KEEPER; START clears tally; rst mid-GOAL -> all 0.
//  Video: out.rgb box edge pixels at h=100 and h=199 coloured, h=200 not; syncs aligned 1 cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level types for the keeper/shooter control chain.
//   g_state  : top-level game phase (the keeper round runs only in KEEPER)
//   g_mode   : SOLO (timed shot) or MULTI (human shooter drives enemy_input)
//   kstate_t : keeper round FSM encoding
//   C_HINT / C_GOAL / C_SAVE : overlay colours (12-bit RGB 4:4:4)
package game_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    SHOOTER = 2'd1,
    KEEPER  = 2'd2,
    FINISH  = 2'd3
  } g_state;

  typedef enum logic {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } g_mode;

  typedef enum logic [2:0] {
    K_IDLE   = 3'd0,
    K_ENGAGE = 3'd1,
    K_REACT  = 3'd2,
    K_JUDGE  = 3'd3,
    K_GOAL   = 3'd4,
    K_MISS   = 3'd5,
    K_TERM   = 3'd6
  } kstate_t;

  localparam logic [11:0] C_HINT = 12'h00F;
  localparam logic [11:0] C_GOAL = 12'hF00;
  localparam logic [11:0] C_SAVE = 12'h0F0;

endpackage

// File: rtl/vga_if.sv
// VGA timing/pixel bundle passed along the video chain.
//   hcount/vcount : current pixel position
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 12-bit pixel colour
// Modport in  : consumer side.  Modport out : producer side.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond strobe generator.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   ms_tick out one-cycle pulse every CLK_HZ/1000 cycles
// With CLK_HZ/1000 <= 1 the strobe is held high (one tick per cycle).
module ms_tick_gen #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CW'(DIV - 1);
    end else if (cnt == '0) begin
      cnt <= CW'(DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign ms_tick = (cnt == '0);

endmodule

// File: rtl/keeper_round_ctrl.sv
// Goalkeeper round controller: sequences one keeper round, overlays the shot
// target on the video stream and keeps the per-match round/goal tally.
//   clk, rst          clock, synchronous active-high reset
//   xpos, ypos        glove position
//   game_state        round runs only while KEEPER; START in IDLE clears tally
//   game_mode         SOLO / MULTI, latched when a round starts
//   shot_xpos/ypos    target top-left, latched on entry to REACT
//   enemy_input       MULTI: shooter has fired (level)
//   is_scored         high while in GOAL
//   round_done        pulse on last SHOW cycle
//   end_gk            pulse in TERM
//   goals_cnt         goals conceded this match
//   round_cnt         completed rounds this match
//   match_over        round_cnt has reached MAX_ROUNDS
//   in / out          video stream, out registered one cycle after in
// Build option: KEEPER_TARGET_HINT_EN draws the target during REACT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// K_IDLE   | waiting for KEEPER (and no match_over)
// K_ENGAGE | SOLO: fixed delay; MULTI: wait for shooter or forfeit
// K_REACT  | glove reaction window, target latched
// K_JUDGE  | one-cycle save/goal decision
// K_GOAL   | goal conceded, red box shown
// K_MISS   | saved or forfeited, green box shown
// K_TERM   | one-cycle end_gk pulse, back to IDLE
module keeper_round_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 65_000_000,
  parameter int ENGAGE_MS   = 1000,
  parameter int REACT_MS    = 1000,
  parameter int SHOW_MS     = 200,
  parameter int WAIT_MS     = 5000,
  parameter int TARGET_W    = 100,
  parameter int TARGET_H    = 100,
  parameter int SAVE_MARGIN = 0,
  parameter int MAX_ROUNDS  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  g_state      game_state,
  input  g_mode       game_mode,
  input  logic [9:0]  shot_xpos,
  input  logic [9:0]  shot_ypos,
  input  logic        enemy_input,
  output logic        is_scored,
  output logic        round_done,
  output logic        end_gk,
  output logic [3:0]  goals_cnt,
  output logic [3:0]  round_cnt,
  output logic        match_over,
  vga_if.in           in,
  vga_if.out          out
);

  localparam int TMR_W = 16;

  kstate_t          state, state_nx;
  g_mode            mode_q;
  logic [TMR_W-1:0] tmr, tmr_load;
  logic [9:0]       sx, sy;
  logic [3:0]       goals_q, rounds_q;
  logic             ms_tick, expire, save, in_box;
  logic             tally_inc, goal_inc;
  logic [12:0]      sx13, sy13, x_lo, x_hi, y_lo, y_hi, h13, v13;
  logic [11:0]      rgb_nx;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick)
  );

  // Phase timer is a down-counter loaded on every state change.
  assign expire = ms_tick && (tmr == '0);

  // Judge window in 13 bits so the upper edge never wraps; lower edge clamps at 0.
  assign sx13 = {3'b000, sx};
  assign sy13 = {3'b000, sy};
  assign x_lo = (sx13 >= 13'(SAVE_MARGIN)) ? sx13 - 13'(SAVE_MARGIN) : 13'd0;
  assign y_lo = (sy13 >= 13'(SAVE_MARGIN)) ? sy13 - 13'(SAVE_MARGIN) : 13'd0;
  assign x_hi = sx13 + 13'(TARGET_W + SAVE_MARGIN - 1);
  assign y_hi = sy13 + 13'(TARGET_H + SAVE_MARGIN - 1);
  assign save = ({1'b0, xpos} >= x_lo) && ({1'b0, xpos} <= x_hi) &&
                ({1'b0, ypos} >= y_lo) && ({1'b0, ypos} <= y_hi);

  assign h13    = {2'b00, in.hcount};
  assign v13    = {2'b00, in.vcount};
  assign in_box = (h13 >= sx13) && (h13 <= sx13 + 13'(TARGET_W - 1)) &&
                  (v13 >= sy13) && (v13 <= sy13 + 13'(TARGET_H - 1));

  assign goals_cnt  = goals_q;
  assign round_cnt  = rounds_q;
  assign match_over = (rounds_q >= 4'(MAX_ROUNDS));

  always_comb begin
    state_nx   = state;
    is_scored  = 1'b0;
    round_done = 1'b0;
    end_gk     = 1'b0;
    tally_inc  = 1'b0;
    goal_inc   = 1'b0;
    case (state)
      K_IDLE: begin
        if (game_state == KEEPER && !match_over) state_nx = K_ENGAGE;
      end
      K_ENGAGE: begin
        if (game_state != KEEPER) begin
          state_nx = K_IDLE;
        end else if (mode_q == MULTI) begin
          if (enemy_input)  state_nx = K_REACT;
          else if (expire)  state_nx = K_MISS;
        end else if (expire) begin
          state_nx = K_REACT;
        end
      end
      K_REACT: begin
        if (game_state != KEEPER) state_nx = K_IDLE;
        else if (expire)          state_nx = K_JUDGE;
      end
      K_JUDGE: begin
        state_nx = save ? K_MISS : K_GOAL;
      end
      K_GOAL: begin
        is_scored = 1'b1;
        if (expire) begin
          round_done = 1'b1;
          tally_inc  = 1'b1;
          goal_inc   = 1'b1;
          state_nx   = K_TERM;
        end
      end
      K_MISS: begin
        if (expire) begin
          round_done = 1'b1;
          tally_inc  = 1'b1;
          state_nx   = K_TERM;
        end
      end
      K_TERM: begin
        end_gk   = 1'b1;
        state_nx = K_IDLE;
      end
      default: state_nx = K_IDLE;
    endcase
  end

  // ENGAGE is only ever entered from IDLE, so the live game_mode is the round's mode.
  always_comb begin
    tmr_load = '0;
    case (state_nx)
      K_ENGAGE:       tmr_load = (game_mode == MULTI) ? TMR_W'(WAIT_MS - 1) : TMR_W'(ENGAGE_MS - 1);
      K_REACT:        tmr_load = TMR_W'(REACT_MS - 1);
      K_GOAL, K_MISS: tmr_load = TMR_W'(SHOW_MS - 1);
      default:        tmr_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= K_IDLE;
      mode_q   <= SOLO;
      tmr      <= '0;
      sx       <= '0;
      sy       <= '0;
      goals_q  <= '0;
      rounds_q <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)        tmr <= tmr_load;
      else if (ms_tick && tmr != '0) tmr <= tmr - 1'b1;
      if (state == K_IDLE && state_nx == K_ENGAGE) mode_q <= game_mode;
      if (state == K_ENGAGE && state_nx == K_REACT) begin
        sx <= shot_xpos;
        sy <= shot_ypos;
      end
      if (state == K_IDLE && game_state == START) begin
        goals_q  <= '0;
        rounds_q <= '0;
      end else if (tally_inc) begin
        if (rounds_q < 4'(MAX_ROUNDS))             rounds_q <= rounds_q + 4'd1;
        if (goal_inc && goals_q < 4'(MAX_ROUNDS))  goals_q  <= goals_q + 4'd1;
      end
    end
  end

  always_comb begin
    rgb_nx = in.rgb;
    case (state)
      K_IDLE, K_ENGAGE, K_JUDGE, K_TERM: rgb_nx = in.rgb;
      K_REACT: begin
`ifdef KEEPER_TARGET_HINT_EN
        if (in_box) rgb_nx = C_HINT;
`else
        rgb_nx = in.rgb;
`endif
      end
      K_GOAL:  if (in_box) rgb_nx = C_GOAL;
      K_MISS:  if (in_box) rgb_nx = C_SAVE;
      default: rgb_nx = C_HINT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= rgb_nx;
    end
  end

endmodule

// File: tb/tb_keeper_round_ctrl.sv
module tb_keeper_round_ctrl;
  import game_pkg::*;

  localparam int CLK_HZ    = 1000;
  localparam int ENGAGE_MS = 10;
  localparam int REACT_MS  = 10;
  localparam int SHOW_MS   = 4;
  localparam int WAIT_MS   = 20;
  localparam int TW        = 100;
  localparam int TH        = 100;
  localparam int MARGIN    = 5;
  localparam int MAXR      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = '0, ypos = '0;
  g_state      game_state = SHOOTER;
  g_mode       game_mode = SOLO;
  logic [9:0]  shot_xpos = '0, shot_ypos = '0;
  logic        enemy_input = 1'b0;
  logic        is_scored, round_done, end_gk, match_over;
  logic [3:0]  goals_cnt, round_cnt;

  vga_if vin ();
  vga_if vout ();

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keeper_round_ctrl #(
    .CLK_HZ(CLK_HZ), .ENGAGE_MS(ENGAGE_MS), .REACT_MS(REACT_MS), .SHOW_MS(SHOW_MS),
    .WAIT_MS(WAIT_MS), .TARGET_W(TW), .TARGET_H(TH), .SAVE_MARGIN(MARGIN), .MAX_ROUNDS(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .game_state(game_state),
    .game_mode(game_mode), .shot_xpos(shot_xpos), .shot_ypos(shot_ypos),
    .enemy_input(enemy_input), .is_scored(is_scored), .round_done(round_done),
    .end_gk(end_gk), .goals_cnt(goals_cnt), .round_cnt(round_cnt),
    .match_over(match_over), .in(vin), .out(vout)
  );

  typedef struct {
    g_mode mode;
    int gx, gy, sx, sy, enemy_at, abort_at;
    int e_done, e_sc, e_len, e_rounds, e_goals;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: outcome of one round from the game rules, in plain integers.
  task automatic predict(input vec_t s, output int e_done, output int e_sc, output int e_len);
    int lo_x, hi_x, lo_y, hi_y;
    bit saved;
    if (s.abort_at > 0) begin
      e_done = 0; e_sc = 0; e_len = -1;
    end else if (s.mode == MULTI && s.enemy_at == 0) begin
      e_done = 1; e_sc = 0; e_len = WAIT_MS + SHOW_MS + 1;
    end else begin
      lo_x = (s.sx - MARGIN < 0) ? 0 : s.sx - MARGIN;
      lo_y = (s.sy - MARGIN < 0) ? 0 : s.sy - MARGIN;
      hi_x = s.sx + TW - 1 + MARGIN;
      hi_y = s.sy + TH - 1 + MARGIN;
      saved = (s.gx >= lo_x) && (s.gx <= hi_x) && (s.gy >= lo_y) && (s.gy <= hi_y);
      e_done = 1;
      e_sc   = saved ? 0 : SHOW_MS;
      e_len  = ((s.mode == SOLO) ? ENGAGE_MS : s.enemy_at) + REACT_MS + SHOW_MS + 2;
    end
  endtask

  // Called at a negedge; cycle n is the n-th negedge after KEEPER is raised.
  task automatic run_round(input vec_t s, output int n_done, output int n_gk,
                           output int n_sc, output int len);
    n_done = 0; n_gk = 0; n_sc = 0; len = -1;
    game_mode   = s.mode;
    xpos        = 12'(s.gx);
    ypos        = 12'(s.gy);
    shot_xpos   = 10'(s.sx);
    shot_ypos   = 10'(s.sy);
    enemy_input = 1'b0;
    game_state  = KEEPER;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      n_done += int'(round_done);
      n_gk   += int'(end_gk);
      n_sc   += int'(is_scored);
      if (n == s.enemy_at) enemy_input = 1'b1;
      if (n == s.abort_at) game_state = SHOOTER;
      if (end_gk) begin
        len = n;
        game_state = SHOOTER;
        break;
      end
      if (s.abort_at > 0 && n >= s.abort_at + 15) break;
    end
    enemy_input = 1'b0;
    game_state  = SHOOTER;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_tally();
    game_state = START;
    repeat (2) @(negedge clk);
    game_state = SHOOTER;
    @(negedge clk);
  endtask

  // Background video stimulus: syncs, blanks and colour change just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      vin.hsync = 1'($urandom);
      vin.vsync = 1'($urandom);
      vin.hblnk = 1'($urandom);
      vin.vblnk = 1'($urandom);
      vin.rgb   = 12'($urandom);
    end
  end

  // Every video field except rgb must appear on out exactly one cycle later.
  initial begin
    logic        p_hs, p_vs, p_hb, p_vb, p_rst;
    logic [10:0] p_h, p_v;
    forever begin
      @(posedge clk);
      p_hs = vin.hsync; p_vs = vin.vsync; p_hb = vin.hblnk; p_vb = vin.vblnk;
      p_h = vin.hcount; p_v = vin.vcount; p_rst = rst;
      @(negedge clk);
      if (!p_rst)
        check("video_pipe",
              {vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.hcount, vout.vcount},
              {p_hs, p_vs, p_hb, p_vb, p_h, p_v});
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    vec_t s;
    int n_done, n_gk, n_sc, len, e_done, e_sc, e_len;
    int mr, mg, pulses;
    bit found;
    logic [11:0] cap;

    vin.hcount = '0;
    vin.vcount = '0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    //            mode  gx   gy   sx   sy  en ab done sc len rnd gl
    vt[0]  = '{SOLO,  150, 150, 100, 100, 0, 0,  1, 0, 26, 1, 0};
    vt[1]  = '{SOLO,  400, 400, 100, 100, 0, 0,  1, 4, 26, 1, 1};
    vt[2]  = '{SOLO,   95,  95, 100, 100, 0, 0,  1, 0, 26, 1, 0};
    vt[3]  = '{SOLO,   94, 100, 100, 100, 0, 0,  1, 4, 26, 1, 1};
    vt[4]  = '{SOLO,  204, 204, 100, 100, 0, 0,  1, 0, 26, 1, 0};
    vt[5]  = '{SOLO,  205, 150, 100, 100, 0, 0,  1, 4, 26, 1, 1};
    vt[6]  = '{MULTI, 400, 400, 100, 100, 0, 0,  1, 0, 25, 1, 0};
    vt[7]  = '{MULTI, 400, 400, 100, 100, 3, 0,  1, 4, 19, 1, 1};
    vt[8]  = '{MULTI, 150, 150, 100, 100, 7, 0,  1, 0, 23, 1, 0};
    vt[9]  = '{SOLO,    0,   0,   3,   3, 0, 0,  1, 0, 26, 1, 0};
    vt[10] = '{SOLO,  400, 400, 100, 100, 0, 15, 0, 0, -1, 0, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_is_scored", is_scored, 0);
    check("rst_round_done", round_done, 0);
    check("rst_end_gk", end_gk, 0);
    check("rst_goals", goals_cnt, 0);
    check("rst_rounds", round_cnt, 0);
    check("rst_match_over", match_over, 0);
    check("rst_out_rgb", vout.rgb, 0);
    check("rst_out_sync", {vout.hsync, vout.vsync, vout.hcount}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      clear_tally();
      run_round(vt[i], n_done, n_gk, n_sc, len);
      check($sformatf("vec%0d_round_done", i), n_done, vt[i].e_done);
      check($sformatf("vec%0d_end_gk", i), n_gk, vt[i].e_done);
      check($sformatf("vec%0d_scored_cycles", i), n_sc, vt[i].e_sc);
      check($sformatf("vec%0d_length", i), len, vt[i].e_len);
      check($sformatf("vec%0d_round_cnt", i), round_cnt, vt[i].e_rounds);
      check($sformatf("vec%0d_goals_cnt", i), goals_cnt, vt[i].e_goals);
    end

    // Two rounds end the match; KEEPER then starts nothing until START.
    clear_tally();
    run_round(vt[1], n_done, n_gk, n_sc, len);
    run_round(vt[0], n_done, n_gk, n_sc, len);
    check("match_over_set", match_over, 1);
    check("match_rounds", round_cnt, 2);
    check("match_goals", goals_cnt, 1);
    game_state = KEEPER;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      pulses += int'(round_done) + int'(end_gk) + int'(is_scored);
    end
    game_state = SHOOTER;
    check("match_idle_pulses", pulses, 0);
    check("match_idle_rounds", round_cnt, 2);
    clear_tally();
    check("start_clear_rounds", round_cnt, 0);
    check("start_clear_goals", goals_cnt, 0);
    check("start_clear_match_over", match_over, 0);

    // Reset while in GOAL.
    clear_tally();
    game_mode = SOLO; xpos = 12'd400; ypos = 12'd400; shot_xpos = 10'd100; shot_ypos = 10'd100;
    game_state = KEEPER;
    found = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (is_scored) begin found = 1; break; end
    end
    check("rstgoal_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstgoal_outputs", {is_scored, round_done, end_gk, match_over, goals_cnt, round_cnt}, 0);
    check("rstgoal_out_rgb", vout.rgb, 0);
    game_state = SHOOTER;
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      pulses += int'(round_done) + int'(end_gk) + int'(is_scored);
    end
    check("rstgoal_no_pulses", pulses, 0);
    check("rstgoal_rounds", round_cnt, 0);

    // Video overlay during REACT and GOAL, box at h in [100,199].
    clear_tally();
    game_mode = SOLO; xpos = 12'd400; ypos = 12'd400; shot_xpos = 10'd100; shot_ypos = 10'd100;
    vin.vcount = 11'd150;
    game_state = KEEPER;
    repeat (14) @(negedge clk);
    vin.hcount = 11'd150;
    @(posedge clk); cap = vin.rgb;
    @(negedge clk);
`ifdef KEEPER_TARGET_HINT_EN
    check("vid_react_rgb", vout.rgb, C_HINT);
`else
    check("vid_react_rgb", vout.rgb, cap);
`endif
    found = 0;
    for (int n = 0; n < 20; n++) begin
      if (is_scored) begin found = 1; break; end
      @(negedge clk);
    end
    check("vid_goal_reached", found, 1);
    vin.hcount = 11'd100;
    @(posedge clk); cap = vin.rgb;
    @(negedge clk);
    check("vid_h100", vout.rgb, C_GOAL);
    vin.hcount = 11'd199;
    @(posedge clk); cap = vin.rgb;
    @(negedge clk);
    check("vid_h199", vout.rgb, C_GOAL);
    vin.hcount = 11'd200;
    @(posedge clk); cap = vin.rgb;
    @(negedge clk);
    check("vid_h200", vout.rgb, cap);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      if (end_gk) begin found = 1; break; end
      @(negedge clk);
    end
    check("vid_end_gk", found, 1);
    game_state = SHOOTER;
    vin.hcount = '0;
    vin.vcount = '0;
    repeat (2) @(negedge clk);

    // Randomised rounds against the reference, tally tracked across rounds.
    clear_tally();
    mr = 0; mg = 0;
    for (int i = 0; i < 40; i++) begin
      if (mr == MAXR) begin
        clear_tally();
        mr = 0; mg = 0;
      end
      s.mode = g_mode'($urandom_range(0, 1));
      s.sx = int'($urandom_range(0, 600));
      s.sy = int'($urandom_range(0, 600));
      s.gx = s.sx + int'($urandom_range(0, 130)) - 15;
      s.gy = s.sy + int'($urandom_range(0, 130)) - 15;
      if (s.gx < 0) s.gx = 0;
      if (s.gy < 0) s.gy = 0;
      s.enemy_at = (s.mode == MULTI && $urandom_range(0, 3) != 0) ? int'($urandom_range(1, WAIT_MS - 1)) : 0;
      s.abort_at = (s.mode == SOLO && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, ENGAGE_MS + REACT_MS)) : 0;
      predict(s, e_done, e_sc, e_len);
      run_round(s, n_done, n_gk, n_sc, len);
      if (e_done == 1) begin
        if (mr < MAXR) mr++;
        if (e_sc > 0 && mg < MAXR) mg++;
      end
      check($sformatf("rnd%0d_round_done", i), n_done, e_done);
      check($sformatf("rnd%0d_end_gk", i), n_gk, e_done);
      check($sformatf("rnd%0d_scored_cycles", i), n_sc, e_sc);
      check($sformatf("rnd%0d_length", i), len, e_len);
      check($sformatf("rnd%0d_round_cnt", i), round_cnt, mr);
      check($sformatf("rnd%0d_goals_cnt", i), goals_cnt, mg);
      check($sformatf("rnd%0d_match_over", i), match_over, (mr == MAXR) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
